// File: rtl/soc_mem_arbiter_if.sv
// soc_mem_arbiter_if: fetch port, data port and unified slave port
// of the two-master memory arbiter.
interface soc_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic              i_ce;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_stall;
  logic              d_ce;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              m_req;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              bus_err;

  modport slave (
    input  i_ce, i_addr,
    output i_data, i_stall,
    input  d_ce, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_stall,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_ack,
    output bus_err
  );

  modport master (
    output i_ce, i_addr,
    input  i_data, i_stall,
    output d_ce, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_stall,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_ack,
    input  bus_err
  );
endinterface

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: fetch + data masters onto one req/ack slave port,
// fixed or round-robin priority, back-to-back grants, ack timeout.
module soc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BE_W    = DATA_W / 8,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  soc_mem_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  state_t            state;
  logic              mReq;
  logic              mWe;
  logic [BE_W-1:0]   mBe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mWdata;
  logic [DATA_W-1:0] iDataQ;
  logic [DATA_W-1:0] dDataQ;
  logic [CW-1:0]     tmoCnt;
  logic              rrNextI;

  logic              inGnt;
  logic              ack;
  logic              tmo;
  logic              done;
  logic              iDone;
  logic              dDone;
  logic              grantI;
  logic              grantD;
  logic [DATA_W-1:0] rsp;

  assign inGnt = (state == GNT_I) || (state == GNT_D);
  assign ack   = inGnt && bus.m_ack;
  assign tmo   = TMO_EN && inGnt && (tmoCnt == TMO_LAST);
  assign done  = ack || tmo;
  assign iDone = done && (state == GNT_I);
  assign dDone = done && (state == GNT_D);
  // A timed-out access returns zero instead of bus garbage
  assign rsp   = ack ? bus.m_rdata : '0;

  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    unique case (state)
      IDLE: begin
        grantI = bus.i_ce &&
          (!bus.d_ce || ((RR_MODE != 0) && rrNextI));
        grantD = bus.d_ce && !grantI;
      end
      GNT_I: grantD = done && bus.d_ce;
      GNT_D: grantI = done && bus.i_ce;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mReq    <= 1'b0;
      mWe     <= 1'b0;
      mBe     <= '0;
      mAddr   <= '0;
      mWdata  <= '0;
      iDataQ  <= '0;
      dDataQ  <= '0;
      tmoCnt  <= '0;
      rrNextI <= 1'b1;
    end else begin
      if (grantI) begin
        state   <= GNT_I;
        mReq    <= 1'b1;
        mWe     <= 1'b0;
        mBe     <= '1;
        mAddr   <= bus.i_addr;
        mWdata  <= '0;
        tmoCnt  <= '0;
        rrNextI <= 1'b0;
      end else if (grantD) begin
        state   <= GNT_D;
        mReq    <= 1'b1;
        mWe     <= bus.d_we;
        mBe     <= bus.d_be;
        mAddr   <= bus.d_addr;
        mWdata  <= bus.d_wdata;
        tmoCnt  <= '0;
        rrNextI <= 1'b1;
      end else if (done) begin
        state <= IDLE;
        mReq  <= 1'b0;
      end else if (inGnt) begin
        tmoCnt <= tmoCnt + CW'(1);
      end
      // A master that dropped ce early gets no result
      if (iDone && bus.i_ce)
        iDataQ <= rsp;
      if (dDone && bus.d_ce && !mWe)
        dDataQ <= rsp;
    end
  end

  assign bus.i_stall = bus.i_ce && !iDone;
  assign bus.d_stall = bus.d_ce && !dDone;
  assign bus.i_data  = (iDone && bus.i_ce) ? rsp : iDataQ;
  assign bus.d_rdata =
    (dDone && bus.d_ce && !mWe) ? rsp : dDataQ;
  assign bus.m_req   = mReq;
  assign bus.m_we    = mWe;
  assign bus.m_be    = mBe;
  assign bus.m_addr  = mAddr;
  assign bus.m_wdata = mWdata;
  assign bus.bus_err = tmo && !ack;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: directed vectors for the fetch/data arbiter,
// fixed priority + timeout on one instance, round-robin on another.
module tb_soc_mem_arbiter;

  logic clk;
  logic rst0;
  logic rst1;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  soc_mem_arbiter_if bus0 ();
  soc_mem_arbiter_if bus1 ();

  soc_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BE_W(4),
    .RR_MODE(0), .TIMEOUT(4)
  ) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave)
  );

  soc_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BE_W(4),
    .RR_MODE(1), .TIMEOUT(16)
  ) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1.slave)
  );

  typedef struct {
    logic        ice;
    logic [31:0] ia;
    logic        dce;
    logic        dwe;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        xIs;
    logic        xDs;
    logic        xMr;
    logic [31:0] xMa;
    logic        xMw;
    logic [3:0]  xMb;
    logic [31:0] xId;
    logic [31:0] xDr;
    logic        xBe;
  } vec_t;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  vec_t tv[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv0(input logic ice, input logic [31:0] ia,
                      input logic dce, input logic dwe,
                      input logic [3:0] be, input logic [31:0] da,
                      input logic [31:0] wd, input logic ack,
                      input logic [31:0] rd);
    bus0.i_ce    = ice;
    bus0.i_addr  = ia;
    bus0.d_ce    = dce;
    bus0.d_we    = dwe;
    bus0.d_be    = be;
    bus0.d_addr  = da;
    bus0.d_wdata = wd;
    bus0.m_ack   = ack;
    bus0.m_rdata = rd;
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rrSeen[4];
  logic [31:0] rrExp[4];
  int          got;

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drv0(N, 0, N, N, 4'h0, 0, 0, N, 0);
    bus1.i_ce    = N;
    bus1.i_addr  = 32'h0;
    bus1.d_ce    = N;
    bus1.d_we    = N;
    bus1.d_be    = 4'h0;
    bus1.d_addr  = 32'h0;
    bus1.d_wdata = 32'h0;
    bus1.m_ack   = N;
    bus1.m_rdata = 32'h0;

    // ice ia dce dwe be da wd ack rd | is ds mr ma mw mb id dr berr
    tv[0]  = '{N, 32'h0,   N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               N, N, N, 32'h0,   N, 4'h0, 32'h0, 32'h0, N};
    tv[1]  = '{Y, 32'h100, N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               Y, N, N, 32'h0,   N, 4'h0, 32'h0, 32'h0, N};
    tv[2]  = '{Y, 32'h100, N, N, 4'h0, 32'h0,  32'h0, Y, 32'h2402000A,
               N, N, Y, 32'h100, N, 4'hF, 32'h2402000A, 32'h0, N};
    tv[3]  = '{N, 32'h0,   N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               N, N, N, 32'h100, N, 4'hF, 32'h2402000A, 32'h0, N};
    tv[4]  = '{Y, 32'h200, Y, Y, 4'h3, 32'h40, 32'h12345678, N, 32'h0,
               Y, Y, N, 32'h100, N, 4'hF, 32'h2402000A, 32'h0, N};
    tv[5]  = '{Y, 32'h200, Y, Y, 4'h3, 32'h40, 32'h12345678, N, 32'h0,
               Y, Y, Y, 32'h40,  Y, 4'h3, 32'h2402000A, 32'h0, N};
    tv[6]  = tv[5];
    tv[7]  = '{Y, 32'h200, Y, Y, 4'h3, 32'h40, 32'h12345678, Y, 32'hDEADBEEF,
               Y, N, Y, 32'h40,  Y, 4'h3, 32'h2402000A, 32'h0, N};
    tv[8]  = '{Y, 32'h200, N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               Y, N, Y, 32'h200, N, 4'hF, 32'h2402000A, 32'h0, N};
    tv[9]  = tv[8];
    tv[10] = '{Y, 32'h200, N, N, 4'h0, 32'h0,  32'h0, Y, 32'h11112222,
               N, N, Y, 32'h200, N, 4'hF, 32'h11112222, 32'h0, N};
    tv[11] = '{N, 32'h0,   N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               N, N, N, 32'h200, N, 4'hF, 32'h11112222, 32'h0, N};
    tv[12] = '{N, 32'h0,   Y, N, 4'hF, 32'h40, 32'h0, N, 32'h0,
               N, Y, N, 32'h200, N, 4'hF, 32'h11112222, 32'h0, N};
    tv[13] = '{N, 32'h0,   Y, N, 4'hF, 32'h40, 32'h0, Y, 32'hCAFEF00D,
               N, N, Y, 32'h40,  N, 4'hF, 32'h11112222, 32'hCAFEF00D, N};
    tv[14] = '{N, 32'h0,   N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               N, N, N, 32'h40,  N, 4'hF, 32'h11112222, 32'hCAFEF00D, N};
    tv[15] = '{N, 32'h0,   Y, Y, 4'hF, 32'h44, 32'h55, N, 32'h0,
               N, Y, N, 32'h40,  N, 4'hF, 32'h11112222, 32'hCAFEF00D, N};
    tv[16] = '{N, 32'h0,   Y, Y, 4'hF, 32'h44, 32'h55, Y, 32'h99999999,
               N, N, Y, 32'h44,  Y, 4'hF, 32'h11112222, 32'hCAFEF00D, N};
    tv[17] = '{N, 32'h0,   N, N, 4'h0, 32'h0,  32'h0, N, 32'h0,
               N, N, N, 32'h44,  Y, 4'hF, 32'h11112222, 32'hCAFEF00D, N};

    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    for (int k = 0; k < 18; k++) begin
      drv0(tv[k].ice, tv[k].ia, tv[k].dce, tv[k].dwe, tv[k].be,
           tv[k].da, tv[k].wd, tv[k].ack, tv[k].rd);
      @(negedge clk);
      chk($sformatf("v%0d_istall", k), 32'(bus0.i_stall), 32'(tv[k].xIs));
      chk($sformatf("v%0d_dstall", k), 32'(bus0.d_stall), 32'(tv[k].xDs));
      chk($sformatf("v%0d_mreq", k), 32'(bus0.m_req), 32'(tv[k].xMr));
      chk($sformatf("v%0d_maddr", k), bus0.m_addr, tv[k].xMa);
      chk($sformatf("v%0d_mwe", k), 32'(bus0.m_we), 32'(tv[k].xMw));
      chk($sformatf("v%0d_mbe", k), 32'(bus0.m_be), 32'(tv[k].xMb));
      chk($sformatf("v%0d_idata", k), bus0.i_data, tv[k].xId);
      chk($sformatf("v%0d_drdata", k), bus0.d_rdata, tv[k].xDr);
      chk($sformatf("v%0d_buserr", k), 32'(bus0.bus_err), 32'(tv[k].xBe));
      nextCyc();
    end

    // Timeout on a data read: slave never acks, TIMEOUT=4
    drv0(N, 0, Y, N, 4'hF, 32'h80, 0, N, 0);
    @(negedge clk);
    chk("tmo_req_dstall", 32'(bus0.d_stall), 32'd1);
    chk("tmo_req_buserr", 32'(bus0.bus_err), 32'd0);
    nextCyc();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("tmo%0d_buserr", k), 32'(bus0.bus_err),
          (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("tmo%0d_dstall", k), 32'(bus0.d_stall),
          (k == 4) ? 32'd0 : 32'd1);
      chk($sformatf("tmo%0d_mreq", k), 32'(bus0.m_req), 32'd1);
      chk($sformatf("tmo%0d_maddr", k), bus0.m_addr, 32'h80);
      if (k == 4)
        chk("tmo_drdata", bus0.d_rdata, 32'h0);
      nextCyc();
    end
    drv0(N, 0, N, N, 4'h0, 0, 0, N, 0);
    @(negedge clk);
    chk("tmo_idle_mreq", 32'(bus0.m_req), 32'd0);
    chk("tmo_idle_buserr", 32'(bus0.bus_err), 32'd0);
    nextCyc();
    drv0(N, 0, N, N, 4'h0, 0, 0, Y, 32'h77);
    @(negedge clk);
    chk("stray_drdata", bus0.d_rdata, 32'h0);
    chk("stray_buserr", 32'(bus0.bus_err), 32'd0);
    chk("stray_mreq", 32'(bus0.m_req), 32'd0);
    nextCyc();

    // Reset in the middle of a fetch
    drv0(Y, 32'h300, N, N, 4'h0, 0, 0, N, 0);
    nextCyc();
    @(negedge clk);
    chk("rst_pre_mreq", 32'(bus0.m_req), 32'd1);
    chk("rst_pre_maddr", bus0.m_addr, 32'h300);
    nextCyc();
    rst0 = 1'b1;
    nextCyc();
    rst0 = 1'b0;
    drv0(N, 0, N, N, 4'h0, 0, 0, Y, 32'hBAD0BAD0);
    @(negedge clk);
    chk("rst_mreq", 32'(bus0.m_req), 32'd0);
    chk("rst_maddr", bus0.m_addr, 32'h0);
    chk("rst_idata", bus0.i_data, 32'h0);
    chk("rst_istall", 32'(bus0.i_stall), 32'd0);
    nextCyc();
    drv0(N, 0, N, N, 4'h0, 0, 0, N, 0);
    @(negedge clk);
    chk("rst_late_ack_idata", bus0.i_data, 32'h0);
    chk("rst_late_ack_mreq", 32'(bus0.m_req), 32'd0);
    nextCyc();
    drv0(Y, 32'h304, N, N, 4'h0, 0, 0, N, 0);
    @(negedge clk);
    chk("post_rst_istall0", 32'(bus0.i_stall), 32'd1);
    chk("post_rst_mreq0", 32'(bus0.m_req), 32'd0);
    nextCyc();
    drv0(Y, 32'h304, N, N, 4'h0, 0, 0, Y, 32'h600DF00D);
    @(negedge clk);
    chk("post_rst_istall1", 32'(bus0.i_stall), 32'd0);
    chk("post_rst_maddr", bus0.m_addr, 32'h304);
    chk("post_rst_idata", bus0.i_data, 32'h600DF00D);
    nextCyc();
    drv0(N, 0, N, N, 4'h0, 0, 0, N, 0);
    @(negedge clk);
    chk("post_rst_hold", bus0.i_data, 32'h600DF00D);
    nextCyc();

    // Round-robin: both ports request continuously, zero-wait slave
    rrExp[0] = 32'h1000;
    rrExp[1] = 32'h2000;
    rrExp[2] = 32'h1000;
    rrExp[3] = 32'h2000;
    for (int k = 0; k < 4; k++) rrSeen[k] = 32'h0;
    got = 0;
    bus1.i_ce   = Y;
    bus1.i_addr = 32'h1000;
    bus1.d_ce   = Y;
    bus1.d_we   = N;
    bus1.d_be   = 4'hF;
    bus1.d_addr = 32'h2000;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus1.m_ack   = bus1.m_req;
      bus1.m_rdata = 32'(c);
      @(negedge clk);
      if (bus1.m_req && bus1.m_ack) begin
        rrSeen[got] = bus1.m_addr;
        got++;
      end
      nextCyc();
    end
    bus1.i_ce  = N;
    bus1.d_ce  = N;
    bus1.m_ack = N;
    chk("rr_count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), rrSeen[k], rrExp[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
- Two-master to one-slave memory arbiter for the next-generation SoC top.
- Instruction fetch and data load/store share a single unified memory port.
- Masters see a stall per port. The slave side uses a req/ack handshake with variable latency.
- Parameters set width, arbitration mode and ack timeout.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width. Must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.
- RR_MODE, 0, arbitration mode: 0 = fixed data-port priority, 1 = round-robin.
- TIMEOUT, 16, slave-ack timeout in cycles. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- i_ce  in  1  fetch request; held with i_addr until i_stall=0
- i_addr  in  ADDR_W  fetch address
- i_data  out  DATA_W  fetch data
- i_stall  out  1  fetch not yet complete
- d_ce  in  1  data request; held with its fields until d_stall=0
- d_we  in  1  1 = write, 0 = read
- d_be  in  BE_W  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data
- d_stall  out  1  data access not yet complete
- m_req  out  1  slave request
- m_we  out  1  slave write
- m_be  out  BE_W  slave byte enables
- m_addr  out  ADDR_W  slave address
- m_wdata  out  DATA_W  slave write data
- m_rdata  in  DATA_W  slave read data, valid when m_ack=1
- m_ack  in  1  slave completion, one-cycle pulse per request
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D.
- Reset, applied at any time including mid-transaction: state=IDLE, m_req=0, m_* fields=0, bus_err=0, held data registers=0, timeout counter=0, RR pointer = instruction port next. An in-flight slave ack after reset is ignored.
- IDLE: requests are sampled each cycle.
  - Only one ce high: grant that port.
  - Both ce high, RR_MODE=0: grant data.
  - Both ce high, RR_MODE=1: grant the port not granted most recently.
- On grant, the next state is GNT_x. m_addr, m_we, m_be, m_wdata are registered from the granted port; m_req=1 from the next cycle on.
- Instruction grants drive m_we=0 and m_be=all ones.
- GNT_x: m_req and all m_* fields stay stable until completion.
- Completion happens in the cycle m_ack=1, or when the timeout counter reaches TIMEOUT-1 with TIMEOUT>0.
  - Read data: i_data or d_rdata = m_rdata combinationally in the completion cycle, and is also registered. Outside the completion cycle each output shows its registered last value.
  - Timeout: the completing port's data is 0 and bus_err pulses for 1 cycle. A later stray m_ack is ignored while in IDLE.
  - Next state: if the other port's ce=1, go directly to GNT_other. The other port's fields are registered that edge and m_req stays 1 (back-to-back, no bubble). Otherwise go to IDLE; m_req=0 next cycle.
  - The port that just completed is never re-granted from its completion cycle. Its ce still describes the finished access.
- Stall: x_stall = x_ce & ~(granted_x & completion), combinational.
  - Minimum access latency: request cycle + grant cycle + ack. With a zero-wait slave (ack in the first m_req cycle), stall is high for 1 cycle.
- Timeout counter: cleared on every grant; increments each GNT cycle without m_ack.
- Writes: d_rdata is unchanged on a write completion.
- A ce deasserted while stalled is a master protocol violation. The granted transaction still completes on the slave side, and its result is discarded.

Test Plan:
- Single fetch, zero-wait slave: i_ce=1, i_addr=0x100; slave acks on the first m_req cycle with 0x2402000A -> m_addr=0x100, m_we=0, m_be=0xF; i_stall high exactly 1 cycle; i_data=0x2402000A.
- Simultaneous requests, RR_MODE=0: i_ce=d_ce=1, d_we=1, d_addr=0x40, d_wdata=0x12345678, d_be=0x3, 2-wait slave -> data served first with m_be=0x3; fetch granted back-to-back with no m_req gap; i_stall clears 3 cycles after d_stall.
- RR_MODE=1, both ports requesting continuously for 4 transactions -> grant order I, D, I, D; no port served twice in a row.
- Timeout, TIMEOUT=4, slave never acks a data read -> bus_err pulses once on the 4th GNT_D cycle; d_rdata=0; d_stall drops that cycle; FSM returns to IDLE.
- Reset mid-operation: rst asserted in GNT_I before ack -> next cycle m_req=0, i_data=0, state IDLE; an ack arriving after reset has no effect; a new fetch after rst=0 completes normally.
- Data read after write, slave returns 0xCAFEF00D to a read at 0x40 -> d_rdata=0xCAFEF00D, held stable through the following idle cycles and an intervening write.
